// File: rtl/sfifo_mch_if.sv
// Handshake and status bundle for the multi-channel FIFO sfifo_mch.
// With HIGH_TH_EN defined it also carries the shared threshold and per-channel threshold flags.
interface sfifo_mch_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 3,
    parameter int NUM_CH        = 4,
    parameter int CH_WIDTH      = 2
);
    logic                  wr;
    logic [CH_WIDTH-1:0]   wr_ch;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd;
    logic [CH_WIDTH-1:0]   rd_ch;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  sfifo_valid;
    logic [NUM_CH-1:0]     sfifo_empty;
    logic [NUM_CH-1:0]     sfifo_full;
    logic                  sfifo_ov;
    logic                  sfifo_ud;
`ifdef HIGH_TH_EN
    logic [POINTER_WIDTH:0] high_th;
    logic [NUM_CH-1:0]      sfifo_high_th;
`endif

    modport master (
        output wr, wr_ch, data_in, rd, rd_ch,
`ifdef HIGH_TH_EN
        output high_th,
        input  sfifo_high_th,
`endif
        input  data_out, sfifo_valid, sfifo_empty, sfifo_full, sfifo_ov, sfifo_ud
    );

    modport slave (
        input  wr, wr_ch, data_in, rd, rd_ch,
`ifdef HIGH_TH_EN
        input  high_th,
        output sfifo_high_th,
`endif
        output data_out, sfifo_valid, sfifo_empty, sfifo_full, sfifo_ov, sfifo_ud
    );
endinterface

// File: rtl/sfifo_mch.sv
// NUM_CH independent FIFOs sharing one memory, one write and one read port steered by channel index.
// Optional macro HIGH_TH_EN adds a shared occupancy threshold with per-channel flags.
module sfifo_mch #(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 3,
    parameter int NUM_CH        = 4,
    parameter int CH_WIDTH      = 2
) (
    input logic         clk,
    input logic         rst_n,
    sfifo_mch_if.slave  bus
);
    localparam int DEPTH = 1 << POINTER_WIDTH;
    localparam int CI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = CI_W + POINTER_WIDTH;

    typedef logic [POINTER_WIDTH:0] ptr_t;

    ptr_t                  wr_ptr [NUM_CH];
    ptr_t                  rd_ptr [NUM_CH];
    logic [DATA_WIDTH-1:0] mem    [NUM_CH*DEPTH];

    logic [NUM_CH-1:0]     empty_v;
    logic [NUM_CH-1:0]     full_v;
    logic [CI_W-1:0]       wr_idx;
    logic [CI_W-1:0]       rd_idx;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_rej;
    logic                  rd_rej;

    logic [DATA_WIDTH-1:0] data_out_p1;
    logic                  vld_p1;
    logic                  ov_p1;
    logic                  ud_p1;

    // Flags come straight from each channel's pointer pair; the MSB is the wrap bit.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_flag
        assign empty_v[c] = (wr_ptr[c] == rd_ptr[c]);
        assign full_v[c]  = (wr_ptr[c][POINTER_WIDTH-1:0] == rd_ptr[c][POINTER_WIDTH-1:0]) &&
                            (wr_ptr[c][POINTER_WIDTH] != rd_ptr[c][POINTER_WIDTH]);
    end

    // Out-of-range channel indices are dropped silently, without ov/ud.
    always_comb begin
        wr_idx  = bus.wr_ch[CI_W-1:0];
        rd_idx  = bus.rd_ch[CI_W-1:0];
        wr_ok   = (32'(bus.wr_ch) < NUM_CH);
        rd_ok   = (32'(bus.rd_ch) < NUM_CH);
        wr_acc  = bus.wr && wr_ok && !full_v[wr_idx];
        wr_rej  = bus.wr && wr_ok &&  full_v[wr_idx];
        rd_acc  = bus.rd && rd_ok && !empty_v[rd_idx];
        rd_rej  = bus.rd && rd_ok &&  empty_v[rd_idx];
        wr_addr = {wr_idx, wr_ptr[wr_idx][POINTER_WIDTH-1:0]};
        rd_addr = {rd_idx, rd_ptr[rd_idx][POINTER_WIDTH-1:0]};
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= bus.data_in;
        end
    end

    // Stage p1: registered read data and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            data_out_p1 <= '0;
            vld_p1      <= 1'b0;
            ov_p1       <= 1'b0;
            ud_p1       <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr[wr_idx] <= wr_ptr[wr_idx] + ptr_t'(1);
            end
            if (rd_acc) begin
                rd_ptr[rd_idx] <= rd_ptr[rd_idx] + ptr_t'(1);
                data_out_p1    <= mem[rd_addr];
            end
            vld_p1 <= rd_acc;
            ov_p1  <= wr_rej;
            ud_p1  <= rd_rej;
        end
    end

    assign bus.data_out    = data_out_p1;
    assign bus.sfifo_valid = vld_p1;
    assign bus.sfifo_ov    = ov_p1;
    assign bus.sfifo_ud    = ud_p1;
    assign bus.sfifo_empty = empty_v;
    assign bus.sfifo_full  = full_v;

`ifdef HIGH_TH_EN
    logic [NUM_CH-1:0] high_th_v;

    // Modulo occupancy never exceeds DEPTH, so a threshold above DEPTH never fires.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_th
        ptr_t occ;
        assign occ          = wr_ptr[c] - rd_ptr[c];
        assign high_th_v[c] = (occ >= bus.high_th);
    end

    assign bus.sfifo_high_th = high_th_v;
`endif

endmodule

// File: tb/tb_sfifo_mch.sv
// Directed self-checking bench for sfifo_mch; covers the HIGH_TH_EN flags when that macro is defined.
module tb_sfifo_mch;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sfifo_mch_if #(.DATA_WIDTH(8), .POINTER_WIDTH(3), .NUM_CH(4), .CH_WIDTH(2)) bus ();

    sfifo_mch #(.DATA_WIDTH(8), .POINTER_WIDTH(3), .NUM_CH(4), .CH_WIDTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic [1:0] wc, input logic [7:0] d,
                       input logic r, input logic [1:0] rc);
        bus.wr      = w;
        bus.wr_ch   = wc;
        bus.data_in = d;
        bus.rd      = r;
        bus.rd_ch   = rc;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.wr      = 1'b0;
        bus.wr_ch   = 2'd0;
        bus.data_in = 8'h00;
        bus.rd      = 1'b0;
        bus.rd_ch   = 2'd0;
`ifdef HIGH_TH_EN
        bus.high_th = 4'd5;
`endif
        #80;
        check("rst_empty", 32'(bus.sfifo_empty), 32'hF);
        check("rst_full",  32'(bus.sfifo_full),  32'h0);
        check("rst_dout",  32'(bus.data_out),    32'h0);
        check("rst_valid", 32'(bus.sfifo_valid), 32'h0);
        check("rst_ov",    32'(bus.sfifo_ov),    32'h0);
        check("rst_ud",    32'(bus.sfifo_ud),    32'h0);
        rst_n = 1'b1;
        cyc(0, 2'd0, 8'h00, 0, 2'd0);

        // Fill channel 2 with 5..12, then overflow with 13.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 2'd2, 8'(5 + i), 0, 2'd0);
            check("fill_full2", 32'(bus.sfifo_full[2]), (i == 7) ? 32'd1 : 32'd0);
        end
        check("fill_empty", 32'(bus.sfifo_empty), 32'hB);
        check("fill_fullv", 32'(bus.sfifo_full),  32'h4);
        cyc(1, 2'd2, 8'd13, 0, 2'd0);
        check("ov_pulse", 32'(bus.sfifo_ov),      32'd1);
        check("ov_full2", 32'(bus.sfifo_full[2]), 32'd1);
        cyc(0, 2'd0, 8'h00, 0, 2'd0);
        check("ov_clear", 32'(bus.sfifo_ov),      32'd0);

        // Drain channel 2 in order, then underflow.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 2'd0, 8'h00, 1, 2'd2);
            check("drain_valid", 32'(bus.sfifo_valid), 32'd1);
            check("drain_data",  32'(bus.data_out),    32'(5 + i));
        end
        check("drain_empty2", 32'(bus.sfifo_empty[2]), 32'd1);
        cyc(0, 2'd0, 8'h00, 1, 2'd2);
        check("ud_pulse", 32'(bus.sfifo_ud),    32'd1);
        check("ud_valid", 32'(bus.sfifo_valid), 32'd0);
        check("ud_hold",  32'(bus.data_out),    32'd12);
        cyc(0, 2'd0, 8'h00, 0, 2'd0);
        check("ud_clear", 32'(bus.sfifo_ud),    32'd0);

        // Interleaved channels must not leak into each other.
        cyc(1, 2'd0, 8'hA0, 0, 2'd0);
        cyc(1, 2'd1, 8'hB1, 0, 2'd0);
        cyc(1, 2'd0, 8'hA2, 0, 2'd0);
        cyc(0, 2'd0, 8'h00, 1, 2'd1);
        check("ilv_ch1",  32'(bus.data_out), 32'hB1);
        cyc(0, 2'd0, 8'h00, 1, 2'd0);
        check("ilv_ch0a", 32'(bus.data_out), 32'hA0);
        cyc(0, 2'd0, 8'h00, 1, 2'd0);
        check("ilv_ch0b", 32'(bus.data_out), 32'hA2);
        check("ilv_empty", 32'(bus.sfifo_empty), 32'hF);

        // Same channel full with wr+rd: oldest word out, write rejected.
        for (int i = 0; i < 8; i++) cyc(1, 2'd1, 8'(8'h10 + i), 0, 2'd0);
        check("sf_full_pre", 32'(bus.sfifo_full[1]), 32'd1);
        cyc(1, 2'd1, 8'h99, 1, 2'd1);
        check("sf_data",  32'(bus.data_out),    32'h10);
        check("sf_valid", 32'(bus.sfifo_valid), 32'd1);
        check("sf_ov",    32'(bus.sfifo_ov),    32'd1);
        check("sf_full_post", 32'(bus.sfifo_full[1]), 32'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 2'd0, 8'h00, 1, 2'd1);
            check("sf_rest", 32'(bus.data_out), 32'(8'h10 + i));
        end
        check("sf_empty1", 32'(bus.sfifo_empty[1]), 32'd1);

        // Same channel empty with wr+rd: write lands, read rejected, no fall-through.
        cyc(1, 2'd0, 8'h5A, 1, 2'd0);
        check("se_ud",     32'(bus.sfifo_ud),       32'd1);
        check("se_valid",  32'(bus.sfifo_valid),    32'd0);
        check("se_empty0", 32'(bus.sfifo_empty[0]), 32'd0);
        cyc(0, 2'd0, 8'h00, 1, 2'd0);
        check("se_data",   32'(bus.data_out),       32'h5A);
        check("se_valid2", 32'(bus.sfifo_valid),    32'd1);

        // Different channels simultaneously: independent.
        cyc(1, 2'd2, 8'h77, 1, 2'd0);
        check("dc_ud",     32'(bus.sfifo_ud),       32'd1);
        check("dc_empty2", 32'(bus.sfifo_empty[2]), 32'd0);
        cyc(1, 2'd0, 8'h66, 1, 2'd2);
        check("dc_data",   32'(bus.data_out),       32'h77);
        check("dc_ud0",    32'(bus.sfifo_ud),       32'd0);
        cyc(0, 2'd0, 8'h00, 1, 2'd0);
        check("dc_data0",  32'(bus.data_out),       32'h66);

        // 20 write/read pairs on channel 3: pointers wrap twice.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 2'd3, 8'(8'h30 + i), 0, 2'd0);
            cyc(0, 2'd0, 8'h00, 1, 2'd3);
            check("wrap_data", 32'(bus.data_out), 32'(8'h30 + i));
        end
        check("wrap_empty", 32'(bus.sfifo_empty), 32'hF);
        check("wrap_full",  32'(bus.sfifo_full),  32'h0);

        // Threshold flag on channel 1, then reset asserted mid-burst.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 2'd1, 8'(8'h40 + i), 0, 2'd0);
`ifdef HIGH_TH_EN
            check("th_rise", 32'(bus.sfifo_high_th[1]), (i == 4) ? 32'd1 : 32'd0);
`endif
        end
        cyc(0, 2'd0, 8'h00, 1, 2'd1);
        check("th_rd_data", 32'(bus.data_out), 32'h40);
`ifdef HIGH_TH_EN
        check("th_fall", 32'(bus.sfifo_high_th[1]), 32'd0);
`endif
        bus.wr      = 1'b1;
        bus.wr_ch   = 2'd1;
        bus.data_in = 8'h50;
        bus.rd      = 1'b1;
        bus.rd_ch   = 2'd1;
        @(posedge clk);
        #1;
        check("mid_valid_pre", 32'(bus.sfifo_valid),    32'd1);
        check("mid_empty_pre", 32'(bus.sfifo_empty[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_empty", 32'(bus.sfifo_empty), 32'hF);
        check("mid_full",  32'(bus.sfifo_full),  32'h0);
        check("mid_dout",  32'(bus.data_out),    32'h0);
        check("mid_valid", 32'(bus.sfifo_valid), 32'h0);
        check("mid_ov",    32'(bus.sfifo_ov),    32'h0);
        check("mid_ud",    32'(bus.sfifo_ud),    32'h0);
`ifdef HIGH_TH_EN
        check("mid_th",    32'(bus.sfifo_high_th), 32'h0);
`endif
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 2'd0, 8'h00, 0, 2'd0);
        check("post_empty", 32'(bus.sfifo_empty), 32'hF);
        cyc(0, 2'd0, 8'h00, 1, 2'd1);
        check("post_ud", 32'(bus.sfifo_ud), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
